// File: rtl/common.sv
// Shared definitions for the memory-stage data path.
//   RESET       : active level of the synchronous reset
//   mem_size_t  : access size encoding (2'b11 is the illegal size)
//   Helpers     : alignment check, byte-enable generation, store lane
//                 replication and load extraction/extension for 32-bit words.
package common;

  localparam logic RESET = 1'b1;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  // Byte lanes in a 32-bit data word.
  localparam int DM_LANES = 4;

  // Half needs addr[0]=0, word needs addr[1:0]=0; size 11 is always an error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = off[0];
      MEM_WORD: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [DM_LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [DM_LANES-1:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << off;
      MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; replicating it across the word puts the
  // correct bytes on every lane the byte-enable can select.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      MEM_BYTE: r = {4{wd[7:0]}};
      MEM_HALF: r = {2{wd[15:0]}};
      default:  r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_BYTE: r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      MEM_HALF: r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Byte-lane data RAM: 2^ADDR_W words of NUM_LANES bytes.
//   clk, rst : clock, synchronous active-high reset (clears every word)
//   we, be   : write strobe and per-lane byte enables
//   re       : read strobe; rdata holds its value until the next read
//   addr     : word index shared by read and write
//   wdata    : lane-ordered write data
//   rdata    : registered read data
module data_memory_array
  import common::*;
#(
  parameter int ADDR_W    = 6,
  parameter int NUM_LANES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [NUM_LANES-1:0]        be,
  input  logic [NUM_LANES-1:0][7:0]   wdata,
  output logic [NUM_LANES-1:0][7:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Each lane owns its own storage so a byte write never touches neighbours.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (rst == RESET) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        rd_q <= '0;
      end else begin
        if (we && be[l]) mem[addr] <= wdata[l];
        if (re)          rd_q      <= mem[addr];
      end
    end

    assign rdata[l] = rd_q;
  end

endmodule

// File: rtl/data_memory.sv
// Memory-stage data memory responder with valid/ready request and response
// handshakes and a fixed added access latency.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 : access descriptor, latched on accept
//   rsp_valid / rsp_ready     : response handshake (valid only in RESP)
//   rsp_rdata                 : extended load data, 0 for stores/errors
//   rsp_error                 : misaligned or illegal-size access
module data_memory
  import common::*;
#(
  parameter int DATA_ADDRESS_WIDTH = 6,
  parameter int CPU_DATA_WIDTH     = 32,
  parameter int WAIT_CYCLES        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [DATA_ADDRESS_WIDTH+1:0] req_addr,
  input  logic [CPU_DATA_WIDTH-1:0]     req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CPU_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                          rsp_error
);

  localparam int BAW = DATA_ADDRESS_WIDTH + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                      we;
    logic [1:0]                size;
    logic                      uns;
    logic [BAW-1:0]            addr;
    logic [CPU_DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t req_live, req_q, acc;
  logic err_q;
  logic accept, acc_go, acc_err;
  logic arr_we, arr_re;
  logic [DM_LANES-1:0]      arr_be;
  logic [DM_LANES-1:0][7:0] arr_wdata, arr_rdata;

  assign req_live = '{we: req_we, size: req_size, uns: req_unsigned,
                      addr: req_addr, wdata: req_wdata};

  assign req_ready = (state_q == IDLE) && (rst != RESET);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_go  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        acc_go  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_live;
        err_q <= misaligned(req_size, req_addr[1:0]);
      end
    end
  end

  // With zero added latency the array is accessed on the accept edge itself,
  // before the latched copy exists, so the live request feeds the array.
  assign acc     = (state_q == IDLE) ? req_live : req_q;
  assign acc_err = misaligned(acc.size, acc.addr[1:0]);

  assign arr_we    = acc_go && acc.we && !acc_err;
  assign arr_re    = acc_go && !acc.we && !acc_err;
  assign arr_be    = byte_en(acc.size, acc.addr[1:0]);
  assign arr_wdata = store_lanes(acc.size, acc.wdata);

  data_memory_array #(
    .ADDR_W    (DATA_ADDRESS_WIDTH),
    .NUM_LANES (DM_LANES)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (acc.addr[BAW-1:2]),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // All sources are registers that only change on the edge entering RESP,
  // so the response is stable for as long as RESP is held.
  assign rsp_valid = (state_q == RESP);
  assign rsp_error = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !req_q.we && !err_q)
                   ? load_extend(arr_rdata, req_q.size, req_q.addr[1:0], req_q.uns)
                   : '0;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DATA_ADDRESS_WIDTH, default 6, word-index bits; 64 words; byte address width is DATA_ADDRESS_WIDTH+2.
REQ-002 SHALL have parameter CPU_DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, added access latency, range 0..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  request presented by memory stage.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  DATA_ADDRESS_WIDTH+2  byte address.
REQ-012 req_wdata  in  32  store data, right-aligned.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  memory stage accepts response.
REQ-015 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 rsp_error  out  1  misaligned or illegal-size access.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 Accept occurs when req_valid&&req_ready; all req_* fields SHALL be latched on accept and ignored afterwards.
REQ-019 IDLE->WAIT on accept when WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1); IDLE->RESP on accept when WAIT_CYCLES=0.
REQ-020 WAIT decrements counter each cycle; WAIT->RESP on the cycle counter is 0.
REQ-021 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 Array access (store commit, load capture) SHALL occur on the edge entering RESP; rsp_rdata/rsp_error registered, stable through RESP.
REQ-023 RESP->IDLE when rsp_ready=1; rsp_valid held with stable data while rsp_ready=0 (no timeout).
REQ-024 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> rsp_error=1, rsp_rdata=0, no array write.
REQ-025 Store byte: lane addr[1:0] written with wdata[7:0]; half: lanes {addr[1],0}+1..+0 written with wdata[15:0]; word: all lanes; other lanes unchanged.
REQ-026 Load byte/half: selected lanes shifted to bit 0, extended per req_unsigned; word returned unmodified.
REQ-027 Store response: rsp_valid=1, rsp_rdata=0, rsp_error=0 when aligned.
REQ-028 A new request is not accepted in the RESP->IDLE cycle (req_ready=0 until IDLE); back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-029 Read-after-write to same address SHALL return the newly stored data.

Reset
REQ-030 rst=1 forces IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=0 during the reset cycle, 1 after.
REQ-031 All array words SHALL reset to 0x00000000.
REQ-032 Reset in WAIT SHALL abort the access; a pending store is not committed.

Structure
REQ-033 Constant RESET (1'b1) and enum mem_size_t {MEM_BYTE, MEM_HALF, MEM_WORD} SHALL live in package common; FSM state enum is local.
REQ-034 One sub-module data_memory_array: 2^DATA_ADDRESS_WIDTH x 32 storage, synchronous reset, 4-bit byte-enable write, registered read.

Verification
REQ-035 Reset, then word store 0xDEADBEEF @0x10, word load @0x10 -> rdata 0xDEADBEEF, error 0, rsp_valid 2 cycles after each accept (WAIT_CYCLES=1).
REQ-036 After REQ-035: byte load signed @0x13 -> 0xFFFFFFDE; unsigned @0x13 -> 0x000000DE; half signed @0x10 -> 0xFFFFBEEF.
REQ-037 Byte store 0x55 @0x11, word load @0x10 -> 0xDEAD55EF.
REQ-038 Word store @0x12 and half load @0x01 -> rsp_error=1, rdata 0; following load @0x10 unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0; release -> IDLE next cycle.
REQ-040 Assert rst during WAIT of store 0x12345678 @0x20 -> no response; subsequent load @0x20 -> 0x00000000.
